anemo_poll_master: RTL and testbench



---
 rtl/anemo_poll_pkg.sv | 24 ++
 rtl/anemo_poll_if.sv | 27 ++
 rtl/anemo_poll_timer.sv | 40 ++++
 rtl/anemo_poll_master.sv | 210 +++++++++++++++++++++
 tb/tb_anemo_poll_master.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/anemo_poll_pkg.sv
// anemo_poll_pkg: shared types and constants for the anemometer poll master.
//   state_t       FSM state encoding (IDLE, RD, WR)
//   sat_limit()   largest value representable in an out_w-bit unsigned field
//   DEF_SRC_ADDR  default word address of the measurement register
//   DEF_DST_ADDR  default word address of the output PIO data register
package anemo_poll_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } state_t;

   localparam int DEF_SRC_ADDR = 0;
   localparam int DEF_DST_ADDR = 0;

   // 2^out_w - 1, computed in 33 bits so out_w up to 32 cannot overflow.
   function automatic logic [31:0] sat_limit(input int unsigned out_w);
      logic [32:0] one_shifted;
      one_shifted = 33'(1) << out_w;
      return 32'(one_shifted - 33'(1));
   endfunction

endpackage

// File: rtl/anemo_poll_if.sv
// anemo_poll_if: Avalon-MM bus between the poll master and its slaves.
//   avm_address     word address (ADDR_W bits), master -> slave
//   avm_read        read strobe, master -> slave
//   avm_write       write strobe, master -> slave
//   avm_writedata   32-bit write data, master -> slave
//   avm_readdata    32-bit read data, slave -> master
//   avm_waitrequest slave stall, slave -> master
interface anemo_poll_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic              avm_write;
   logic [31:0]       avm_writedata;
   logic [31:0]       avm_readdata;
   logic              avm_waitrequest;

   modport master (
      output avm_address, avm_read, avm_write, avm_writedata,
      input  avm_readdata, avm_waitrequest
   );

   modport slave (
      input  avm_address, avm_read, avm_write, avm_writedata,
      output avm_readdata, avm_waitrequest
   );
endinterface

// File: rtl/anemo_poll_timer.sv
// anemo_poll_timer: poll-period generator.
//   clk      system clock
//   reset_n  synchronous active-low reset
//   enable   1 = count; 0 = hold at the start of a period, no tick
//   tick     one-cycle pulse on the last cycle of each PERIOD-cycle interval
// Implemented as a down-counter of remaining cycles: rem_q == PERIOD-1 is
// the first cycle of a period and rem_q == 0 the last, so the first tick
// comes PERIOD cycles after enable rises and every PERIOD cycles after that.
module anemo_poll_timer #(
   parameter int PERIOD = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   output logic tick
);
   localparam int               CNT_W = $clog2(PERIOD);
   localparam logic [CNT_W-1:0] LOAD  = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] rem_q, rem_d;

   assign tick = enable && (rem_q == '0);

   always_comb begin
      rem_d = rem_q;
      if (!enable || tick) begin
         rem_d = LOAD;
      end else begin
         rem_d = rem_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rem_q <= LOAD;
      end else begin
         rem_q <= rem_d;
      end
   end
endmodule

// File: rtl/anemo_poll_master.sv
// anemo_poll_master: Avalon-MM initiator that reads a 32-bit measurement
// word, saturates it to OUT_W bits and writes it to an output PIO slave,
// either every PERIOD cycles (enable=1) or on a start pulse.
//   clk, reset_n  system clock, synchronous active-low reset
//   enable        periodic polling active
//   start         single-cycle request for an immediate poll
//   avm           Avalon-MM master port (anemo_poll_if.master)
//   busy          FSM not in IDLE
//   done          one-cycle pulse after the write phase completes
//   last_value    last saturated value written
//   overrun       sticky: a trigger arrived while busy
//   err           sticky transfer timeout (only with ANEMO_POLL_TIMEOUT_EN)
// Optional build macro ANEMO_POLL_TIMEOUT_EN: abort a transfer after TIMEOUT
// waitrequest-stall cycles. Without it the FSM waits indefinitely and err
// stays 0.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transfer; a trigger (tick or start) launches a read
// RD    | avm_read high at SRC_ADDR until waitrequest drops; capture sat
// WR    | avm_write high at DST_ADDR with sat until waitrequest drops
module anemo_poll_master
   import anemo_poll_pkg::*;
#(
   parameter int ADDR_W   = 4,
   parameter int SRC_ADDR = DEF_SRC_ADDR,
   parameter int DST_ADDR = DEF_DST_ADDR,
   parameter int OUT_W    = 8,
   parameter int PERIOD   = 50000,
   parameter int TIMEOUT  = 255
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             start,
   anemo_poll_if.master     avm,
   output logic             busy,
   output logic             done,
   output logic [OUT_W-1:0] last_value,
   output logic             overrun,
   output logic             err
);
   localparam logic [31:0]       SAT_MAX = sat_limit(OUT_W);
   localparam logic [ADDR_W-1:0] SRC_A   = ADDR_W'(SRC_ADDR);
   localparam logic [ADDR_W-1:0] DST_A   = ADDR_W'(DST_ADDR);

   state_t            state_q, state_d;
   logic              read_q, read_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [OUT_W-1:0]  last_q, last_d;
   logic              done_q, done_d;
   logic              overrun_q, overrun_d;
   logic              err_q, err_d;

   logic              tick;
   logic              trigger;
   logic              stall_expired;
   logic [OUT_W-1:0]  sat;

   anemo_poll_timer #(
      .PERIOD (PERIOD)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .tick    (tick)
   );

   assign trigger = tick || start;

   assign sat = (avm.avm_readdata > SAT_MAX) ? SAT_MAX[OUT_W-1:0]
                                             : avm.avm_readdata[OUT_W-1:0];

`ifdef ANEMO_POLL_TIMEOUT_EN
   localparam int                 STALL_W    = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

   logic [STALL_W-1:0] stall_q, stall_d;

   // stall_q counts the stall cycles already seen in this phase, so the
   // TIMEOUT-th consecutive stall cycle is the one that aborts.
   assign stall_expired = (state_q != ST_IDLE) && avm.avm_waitrequest
                          && (stall_q == STALL_LAST);

   always_comb begin
      stall_d = stall_q;
      if (state_d != state_q) begin
         stall_d = '0;
      end else if ((state_q != ST_IDLE) && avm.avm_waitrequest) begin
         stall_d = stall_q + STALL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign stall_expired  = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      read_d    = read_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      last_d    = last_q;
      done_d    = 1'b0;
      overrun_d = overrun_q;
      err_d     = err_q;

      if (state_q != ST_IDLE && trigger) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (trigger) begin
               state_d = ST_RD;
               read_d  = 1'b1;
               addr_d  = SRC_A;
               if (start) begin
                  overrun_d = 1'b0;
                  err_d     = 1'b0;
               end
            end
         end

         ST_RD: begin
            if (!avm.avm_waitrequest) begin
               state_d = ST_WR;
               read_d  = 1'b0;
               write_d = 1'b1;
               addr_d  = DST_A;
               wdata_d = {{(32 - OUT_W){1'b0}}, sat};
            end else if (stall_expired) begin
               state_d = ST_IDLE;
               read_d  = 1'b0;
               addr_d  = '0;
               err_d   = 1'b1;
            end
         end

         ST_WR: begin
            if (!avm.avm_waitrequest) begin
               state_d = ST_IDLE;
               write_d = 1'b0;
               addr_d  = '0;
               last_d  = wdata_q[OUT_W-1:0];
               done_d  = 1'b1;
            end else if (stall_expired) begin
               state_d = ST_IDLE;
               write_d = 1'b0;
               addr_d  = '0;
               err_d   = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            read_d  = 1'b0;
            write_d = 1'b0;
            addr_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         last_q    <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         read_q    <= read_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         last_q    <= last_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
         err_q     <= err_d;
      end
   end

   assign avm.avm_address   = addr_q;
   assign avm.avm_read      = read_q;
   assign avm.avm_write     = write_q;
   assign avm.avm_writedata = wdata_q;

   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;
   assign last_value = last_q;
   assign overrun    = overrun_q;
   assign err        = err_q;
endmodule

// File: tb/tb_anemo_poll_master.sv
// Scoreboard bench for anemo_poll_master: stimulus pushes expected bus
// events (read accept, write accept, done) with their cycle stamps; a
// negedge monitor pops and compares each event the DUT presents.
module tb_anemo_poll_master;
   localparam int SRC = 3;
   localparam int DST = 9;

   localparam int EV_RD   = 0;
   localparam int EV_WR   = 1;
   localparam int EV_DONE = 2;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset_n, enable, start;
   logic       busy, done, overrun, err;
   logic [7:0] last_value;

   logic [31:0] rd_data;
   int          rd_stall, wr_stall;
   logic        hold_wait;
   int          sc;
   logic        prev_rd_s, prev_wr_s;

   int  cyc = 0;
   int  tests = 0;
   int  fails = 0;
   ev_t exp_q[$];

   logic        prev_stall;
   logic        prev_rd, prev_wr;
   logic [3:0]  prev_addr;
   logic [31:0] prev_wdata;

   anemo_poll_if #(.ADDR_W(4)) bus ();

   anemo_poll_master #(
      .ADDR_W   (4),
      .SRC_ADDR (SRC),
      .DST_ADDR (DST),
      .OUT_W    (8),
      .PERIOD   (4),
      .TIMEOUT  (5)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .start      (start),
      .avm        (bus.master),
      .busy       (busy),
      .done       (done),
      .last_value (last_value),
      .overrun    (overrun),
      .err        (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: stalls the first rd_stall / wr_stall cycles of each strobe.
   always @(posedge clk) begin
      #2;
      if (bus.avm_read && prev_rd_s) sc = sc + 1;
      else if (bus.avm_write && prev_wr_s) sc = sc + 1;
      else sc = 0;
      prev_rd_s = bus.avm_read;
      prev_wr_s = bus.avm_write;
      bus.avm_readdata = rd_data;
      if (hold_wait) bus.avm_waitrequest = 1'b1;
      else if (bus.avm_read) bus.avm_waitrequest = (sc < rd_stall);
      else if (bus.avm_write) bus.avm_waitrequest = (sc < wr_stall);
      else bus.avm_waitrequest = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic ev_compare(input ev_t got);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event: got kind=%0d addr=%0h data=%0h cyc=%0d, none expected",
                  got.kind, got.addr, got.data, got.cyc);
         return;
      end
      e = exp_q.pop_front();
      if (got.kind != e.kind || got.addr !== e.addr || got.data !== e.data || got.cyc != e.cyc) begin
         fails++;
         $display("FAIL bus_event: got kind=%0d addr=%0h data=%0h cyc=%0d expected kind=%0d addr=%0h data=%0h cyc=%0d",
                  got.kind, got.addr, got.data, got.cyc, e.kind, e.addr, e.data, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      ev_t g;
      if (bus.avm_read || bus.avm_write) begin
         tests++;
         if (bus.avm_read && bus.avm_write) begin
            fails++;
            $display("FAIL rd_wr_exclusive: got read=1 write=1 expected not both (cycle %0d)", cyc);
         end
      end
      if (prev_stall && busy) begin
         tests++;
         if (bus.avm_read !== prev_rd || bus.avm_write !== prev_wr ||
             bus.avm_address !== prev_addr || bus.avm_writedata !== prev_wdata) begin
            fails++;
            $display("FAIL stall_stable: got rd=%0b wr=%0b addr=%0h wd=%0h expected rd=%0b wr=%0b addr=%0h wd=%0h",
                     bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata,
                     prev_rd, prev_wr, prev_addr, prev_wdata);
         end
      end
      if (bus.avm_read && !bus.avm_waitrequest) begin
         g = '{EV_RD, 32'(bus.avm_address), 32'h0, cyc};
         ev_compare(g);
      end
      if (bus.avm_write && !bus.avm_waitrequest) begin
         g = '{EV_WR, 32'(bus.avm_address), bus.avm_writedata, cyc};
         ev_compare(g);
      end
      if (done) begin
         g = '{EV_DONE, 32'h0, 32'(last_value), cyc};
         ev_compare(g);
      end
      prev_stall = (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
      prev_rd    = bus.avm_read;
      prev_wr    = bus.avm_write;
      prev_addr  = bus.avm_address;
      prev_wdata = bus.avm_writedata;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expected events for a trigger sampled at the end of cycle t0.
   task automatic push_poll(input int t0, input int rs, input int ws, input logic [31:0] sat);
      exp_q.push_back('{EV_RD,   32'(SRC), 32'h0, t0 + 1 + rs});
      exp_q.push_back('{EV_WR,   32'(DST), sat,   t0 + 2 + rs + ws});
      exp_q.push_back('{EV_DONE, 32'h0,    sat,   t0 + 3 + rs + ws});
   endtask

   task automatic poll(input string name, input logic [31:0] data, input logic [31:0] exp_sat,
                       input int rs, input int ws);
      rd_data  = data;
      rd_stall = rs;
      wr_stall = ws;
      push_poll(cyc, rs, ws, exp_sat);
      start = 1'b1;
      step(1);
      start = 1'b0;
      check({name, "_busy"}, 32'(busy), 32'h1);
      step(rs + ws + 3);
      check({name, "_last"}, 32'(last_value), exp_sat);
      check({name, "_idle"}, 32'(busy), 32'h0);
   endtask

   initial begin
      int t0;
      reset_n   = 1'b0;
      enable    = 1'b0;
      start     = 1'b0;
      rd_data   = 32'h0;
      rd_stall  = 0;
      wr_stall  = 0;
      hold_wait = 1'b0;
      sc        = 0;
      prev_rd_s = 1'b0;
      prev_wr_s = 1'b0;
      prev_stall = 1'b0;
      bus.avm_readdata    = 32'h0;
      bus.avm_waitrequest = 1'b0;
      step(3);
      check("rst_busy",    32'(busy), 32'h0);
      check("rst_done",    32'(done), 32'h0);
      check("rst_read",    32'(bus.avm_read), 32'h0);
      check("rst_write",   32'(bus.avm_write), 32'h0);
      check("rst_last",    32'(last_value), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      check("rst_err",     32'(err), 32'h0);
      reset_n = 1'b1;
      step(2);

      poll("zero_wait",  32'h0000_002A, 32'h2A, 0, 0);
      poll("sat_123",    32'h0000_0123, 32'hFF, 0, 0);
      poll("edge_ff",    32'h0000_00FF, 32'hFF, 0, 0);
      poll("edge_100",   32'h0000_0100, 32'hFF, 0, 0);
      poll("all_ones",   32'hFFFF_FFFF, 32'hFF, 0, 0);
      poll("zero",       32'h0000_0000, 32'h00, 0, 0);
      poll("stall_3_2",  32'h0000_007E, 32'h7E, 3, 2);

      // Trigger in the same cycle as done is accepted.
      rd_data = 32'h11; rd_stall = 0; wr_stall = 0;
      t0 = cyc;
      push_poll(t0, 0, 0, 32'h11);
      push_poll(t0 + 3, 0, 0, 32'h11);
      start = 1'b1; step(1); start = 1'b0;
      step(2);
      start = 1'b1; step(1); start = 1'b0;
      step(4);
      check("b2b_overrun", 32'(overrun), 32'h0);

      // Periodic polling with PERIOD=4; start coincident with the first tick,
      // then a start during WR sets overrun.
      rd_data = 32'h80;
      t0 = cyc;
      push_poll(t0 + 3, 0, 0, 32'h80);
      push_poll(t0 + 7, 0, 0, 32'h80);
      enable = 1'b1;
      step(3);
      start = 1'b1; step(1); start = 1'b0;
      step(1);
      start = 1'b1; step(1); start = 1'b0;
      check("ovr_set", 32'(overrun), 32'h1);
      step(3);
      enable = 1'b0;
      step(12);
      check("ovr_sticky", 32'(overrun), 32'h1);
      check("per_idle",   32'(busy), 32'h0);
      poll("ovr_clr", 32'h0000_0042, 32'h42, 0, 0);
      check("ovr_clr_flag", 32'(overrun), 32'h0);

      // Reset for one cycle while the write is stalled.
      rd_data = 32'h99; wr_stall = 10;
      t0 = cyc;
      exp_q.push_back('{EV_RD, 32'(SRC), 32'h0, t0 + 1});
      start = 1'b1; step(1); start = 1'b0;
      step(2);
      check("mid_wr_write", 32'(bus.avm_write), 32'h1);
      reset_n = 1'b0;
      step(1);
      reset_n = 1'b1;
      check("rstwr_write", 32'(bus.avm_write), 32'h0);
      check("rstwr_read",  32'(bus.avm_read), 32'h0);
      check("rstwr_busy",  32'(busy), 32'h0);
      check("rstwr_addr",  32'(bus.avm_address), 32'h0);
      check("rstwr_wdata", bus.avm_writedata, 32'h0);
      check("rstwr_last",  32'(last_value), 32'h0);
      wr_stall = 0;
      step(2);

      // Permanent stall in RD.
      poll("pre_to", 32'h0000_0033, 32'h33, 0, 0);
      rd_data   = 32'h44;
      hold_wait = 1'b1;
      step(1);
      t0 = cyc;
      start = 1'b1; step(1); start = 1'b0;
      step(4);
      check("stall5_read", 32'(bus.avm_read), 32'h1);
      step(1);
`ifdef ANEMO_POLL_TIMEOUT_EN
      check("to_read", 32'(bus.avm_read), 32'h0);
      check("to_err",  32'(err), 32'h1);
      check("to_busy", 32'(busy), 32'h0);
      hold_wait = 1'b0;
      step(3);
      check("to_last", 32'(last_value), 32'h33);
`else
      check("nto_read", 32'(bus.avm_read), 32'h1);
      check("nto_busy", 32'(busy), 32'h1);
      check("nto_err",  32'(err), 32'h0);
      push_poll(t0 + 5, 0, 0, 32'h44);
      hold_wait = 1'b0;
      step(4);
      check("nto_last", 32'(last_value), 32'h44);
`endif
      poll("err_clr", 32'h0000_0005, 32'h05, 0, 0);
      check("err_clr_flag", 32'(err), 32'h0);

      step(5);
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
